// File: rtl/lemon_pkg.sv
// LemonPC shared decode types: op classes, opcodes, immediate formats.
// Imported by decode_logic and decode_stage.
package lemon_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_ALU_R   = 4'd0,
        OP_ALU_I   = 4'd1,
        OP_LOAD    = 4'd2,
        OP_STORE   = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_JAL     = 4'd5,
        OP_JALR    = 4'd6,
        OP_LUI     = 4'd7,
        OP_AUIPC   = 4'd8,
        OP_SYSTEM  = 4'd9,
        OP_ILLEGAL = 4'd10
    } op_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    localparam logic [6:0] OPC_ALU_R  = 7'b0110011;
    localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/decode_logic.sv
// LemonPC combinational instruction decoder.
// Pure function of the instruction word; no state.
module decode_logic
    import lemon_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = 5
) (
    input  logic [31:0]     inst,
    output op_t             op,
    output logic [AW-1:0]   rs1,
    output logic [AW-1:0]   rs2,
    output logic [AW-1:0]   rd,
    output logic            rd_wen,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      funct3,
    output logic            funct7b5
);

    imm_fmt_t    fmt;
    logic        wen_class;
    logic [31:0] imm32;

    assign rs1      = inst[15 +: AW];
    assign rs2      = inst[20 +: AW];
    assign rd       = inst[7 +: AW];
    assign funct3   = inst[14:12];
    assign funct7b5 = inst[30];
    assign rd_wen   = wen_class && (rd != '0);

    // Classify opcode and pick immediate format and source usage.
    always_comb begin
        op        = OP_ILLEGAL;
        fmt       = IMM_NONE;
        wen_class = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        unique case (inst[6:0])
            OPC_ALU_R: begin
                op = OP_ALU_R; wen_class = 1'b1;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_ALU_I: begin
                op = OP_ALU_I; fmt = IMM_I;
                wen_class = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                op = OP_LOAD; fmt = IMM_I;
                wen_class = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                op = OP_STORE; fmt = IMM_S;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                op = OP_BRANCH; fmt = IMM_B;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_JAL: begin
                op = OP_JAL; fmt = IMM_J; wen_class = 1'b1;
            end
            OPC_JALR: begin
                op = OP_JALR; fmt = IMM_I;
                wen_class = 1'b1; uses_rs1 = 1'b1;
            end
            OPC_LUI: begin
                op = OP_LUI; fmt = IMM_U; wen_class = 1'b1;
            end
            OPC_AUIPC: begin
                op = OP_AUIPC; fmt = IMM_U; wen_class = 1'b1;
            end
            OPC_SYSTEM: begin
                op = OP_SYSTEM;
            end
            default: begin
                op = OP_ILLEGAL;
            end
        endcase
    end

    // Assemble the 32-bit immediate for the selected format.
    always_comb begin
        imm32 = '0;
        unique case (fmt)
            IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                            inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm32 = {inst[31:12], 12'b0};
            IMM_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                            inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// LemonPC decode stage: handshake, output register, busy scoreboard.
// Optional same-cycle writeback bypass under DECODE_BYPASS_EN.
module decode_stage
    import lemon_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,
    input  logic            wb_wen,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_imm,
    output logic [AW-1:0]   out_rd,
    output logic            out_rd_wen,
    output op_t             out_op,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5
);

    op_t             d_op;
    logic [AW-1:0]   d_rs1, d_rs2, d_rd;
    logic            d_rd_wen, d_uses_rs1, d_uses_rs2;
    logic [XLEN-1:0] d_imm;
    logic [2:0]      d_funct3;
    logic            d_funct7b5;

    logic [NREG-1:0] busy, busy_next;
    logic            held1, held2, heldd;
    logic            byp1, byp2;
    logic            haz1, haz2, hazd, hazard;
    logic            accept, issue;
    logic [XLEN-1:0] src1, src2;

    decode_logic #(.XLEN(XLEN), .AW(AW)) u_dec (
        .inst     (in_inst),
        .op       (d_op),
        .rs1      (d_rs1),
        .rs2      (d_rs2),
        .rd       (d_rd),
        .rd_wen   (d_rd_wen),
        .uses_rs1 (d_uses_rs1),
        .uses_rs2 (d_uses_rs2),
        .imm      (d_imm),
        .funct3   (d_funct3),
        .funct7b5 (d_funct7b5)
    );

    assign rf_rs1 = d_rs1;
    assign rf_rs2 = d_rs2;

    // The held entry has not set its busy bit yet, so match it directly.
    assign held1 = out_valid && out_rd_wen && (out_rd == d_rs1);
    assign held2 = out_valid && out_rd_wen && (out_rd == d_rs2);
    assign heldd = out_valid && out_rd_wen && (out_rd == d_rd);

`ifdef DECODE_BYPASS_EN
    assign byp1 = wb_wen && (wb_rd == d_rs1) && (d_rs1 != '0);
    assign byp2 = wb_wen && (wb_rd == d_rs2) && (d_rs2 != '0);
    assign src1 = byp1 ? wb_data : rf_data1;
    assign src2 = byp2 ? wb_data : rf_data2;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign src1 = rf_data1;
    assign src2 = rf_data2;
`endif

    // Source and WAW hazards; x0 never stalls.
    always_comb begin
        haz1 = d_uses_rs1 && (d_rs1 != '0) &&
               ((busy[d_rs1] && !byp1) || held1);
        haz2 = d_uses_rs2 && (d_rs2 != '0) &&
               ((busy[d_rs2] && !byp2) || held2);
        hazd = d_rd_wen && (busy[d_rd] || heldd);
        hazard = in_valid && (haz1 || haz2 || hazd);
    end

    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid && out_ready && !flush;

    // Retire clears first so a same-index issue set wins.
    always_comb begin
        busy_next = busy;
        if (wb_wen && (wb_rd != '0))
            busy_next[wb_rd] = 1'b0;
        if (issue && out_rd_wen)
            busy_next[out_rd] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    // Single-entry output register; data holds until next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_src1     <= '0;
            out_src2     <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_rd_wen   <= 1'b0;
            out_op       <= OP_ALU_R;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_src1     <= src1;
            out_src2     <= src2;
            out_imm      <= d_imm;
            out_rd       <= d_rd;
            out_rd_wen   <= d_rd_wen;
            out_op       <= d_op;
            out_funct3   <= d_funct3;
            out_funct7b5 <= d_funct7b5;
        end else if (issue) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table plus hazard,
// backpressure, flush and x0 sequences.
module tb_decode_stage;
    import lemon_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_data1, rf_data2;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc, out_src1, out_src2, out_imm;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    op_t         out_op;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(.XLEN(32), .NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_data1     (rf_data1),
        .rf_data2     (rf_data2),
        .wb_wen       (wb_wen),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_src1     (out_src1),
        .out_src2     (out_src2),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_rd_wen   (out_rd_wen),
        .out_op       (out_op),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        op_t         op;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        wb_wen = 1'b0;
        flush = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        rf_data1 = '0; rf_data2 = '0; wb_wen = 1'b0; wb_rd = '0;
        wb_data = '0; flush = 1'b0; out_ready = 1'b1;

        vecs[0]  = '{32'h00500093, 32'h1000, OP_ALU_I,   5'd1,  1'b1, 32'h5,        3'd0, 1'b0};
        vecs[1]  = '{32'h002081B3, 32'h1004, OP_ALU_R,   5'd3,  1'b1, 32'h0,        3'd0, 1'b0};
        vecs[2]  = '{32'h402081B3, 32'h1008, OP_ALU_R,   5'd3,  1'b1, 32'h0,        3'd0, 1'b1};
        vecs[3]  = '{32'hFFF0A203, 32'h100C, OP_LOAD,    5'd4,  1'b1, 32'hFFFFFFFF, 3'd2, 1'b1};
        vecs[4]  = '{32'h0020A423, 32'h1010, OP_STORE,   5'd8,  1'b0, 32'h8,        3'd2, 1'b0};
        vecs[5]  = '{32'hFE208EE3, 32'h1014, OP_BRANCH,  5'd29, 1'b0, 32'hFFFFFFFC, 3'd0, 1'b1};
        vecs[6]  = '{32'h001000EF, 32'h1018, OP_JAL,     5'd1,  1'b1, 32'h00000800, 3'd0, 1'b0};
        vecs[7]  = '{32'h00C280E7, 32'h101C, OP_JALR,    5'd1,  1'b1, 32'hC,        3'd0, 1'b0};
        vecs[8]  = '{32'hABCDE2B7, 32'h1020, OP_LUI,     5'd5,  1'b1, 32'hABCDE000, 3'd6, 1'b0};
        vecs[9]  = '{32'h12345317, 32'h1024, OP_AUIPC,   5'd6,  1'b1, 32'h12345000, 3'd5, 1'b0};
        vecs[10] = '{32'h00000073, 32'h1028, OP_SYSTEM,  5'd0,  1'b0, 32'h0,        3'd0, 1'b0};
        vecs[11] = '{32'h000000FF, 32'h102C, OP_ILLEGAL, 5'd1,  1'b0, 32'h0,        3'd0, 1'b0};
        vecs[12] = '{32'h00100013, 32'h1030, OP_ALU_I,   5'd0,  1'b0, 32'h1,        3'd0, 1'b0};

        step();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_src1", out_src1, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_busy", dut.busy, 32'd0);

        // Decode table, one instruction per reset.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            do_reset();
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_pc    = vecs[i].pc;
            rf_data1 = 32'h11111111;
            rf_data2 = 32'h22222222;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_op", i), 32'(out_op), 32'(vecs[i].op));
            chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_wen", i), 32'(out_rd_wen), 32'(vecs[i].wen));
            chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("v%0d_f3", i), 32'(out_funct3), 32'(vecs[i].f3));
            chk($sformatf("v%0d_f7b5", i), 32'(out_funct7b5), 32'(vecs[i].f7));
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_src1", i), out_src1, 32'h11111111);
            chk($sformatf("v%0d_src2", i), out_src2, 32'h22222222);
        end

        // RAW: addi x1 then add x2,x1,x1.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h200;
        @(negedge clk);
        chk("raw_first_ready", 32'(in_ready), 32'd1);
        step();
        in_inst = 32'h00108133; in_pc = 32'h204;
        rf_data1 = 32'hDEAD0000; rf_data2 = 32'hDEAD0000;
        @(negedge clk);
        chk("raw_rf_rs1", 32'(rf_rs1), 32'd1);
        chk("raw_rf_rs2", 32'(rf_rs2), 32'd1);
        chk("raw_held_stall", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("raw_busy_set", 32'(dut.busy[1]), 32'd1);
        chk("raw_busy_stall", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        chk("raw_busy_stall2", 32'(in_ready), 32'd0);
        step();
        wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 32'hCAFEF00D;
        @(negedge clk);
`ifdef DECODE_BYPASS_EN
        chk("raw_wb_ready", 32'(in_ready), 32'd1);
        step();
        wb_wen = 1'b0; in_valid = 1'b0;
        rf_data1 = 32'hCAFEF00D; rf_data2 = 32'hCAFEF00D;
`else
        chk("raw_wb_ready", 32'(in_ready), 32'd0);
        step();
        wb_wen = 1'b0;
        rf_data1 = 32'hCAFEF00D; rf_data2 = 32'hCAFEF00D;
        @(negedge clk);
        chk("raw_after_wb_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
`endif
        @(negedge clk);
        chk("raw_out_valid", 32'(out_valid), 32'd1);
        chk("raw_out_op", 32'(out_op), 32'(OP_ALU_R));
        chk("raw_out_src1", out_src1, 32'hCAFEF00D);
        chk("raw_out_src2", out_src2, 32'hCAFEF00D);
        chk("raw_busy_clear", 32'(dut.busy[1]), 32'd0);

        // Backpressure then flush.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h100;
        @(negedge clk);
        chk("bp_first_ready", 32'(in_ready), 32'd1);
        step();
        in_inst = 32'h00900393; in_pc = 32'h104;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_imm", k), out_imm, 32'd5);
            chk($sformatf("bp%0d_rd", k), 32'(out_rd), 32'd1);
            chk($sformatf("bp%0d_pc", k), out_pc, 32'h100);
            chk($sformatf("bp%0d_busy", k), dut.busy, 32'd0);
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_busy", dut.busy, 32'd0);
        chk("fl_next_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_next_valid", 32'(out_valid), 32'd1);
        chk("fl_next_rd", 32'(out_rd), 32'd7);
        chk("fl_next_imm", out_imm, 32'd9);

        // x0 writer does not block a reader of x0.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00100013; in_pc = 32'h300;
        @(negedge clk);
        chk("x0_first_ready", 32'(in_ready), 32'd1);
        step();
        in_inst = 32'h00000133; in_pc = 32'h304;
        @(negedge clk);
        chk("x0_no_stall", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("x0_busy", dut.busy, 32'd0);
        chk("x0_reader_rd", 32'(out_rd), 32'd2);
        chk("x0_reader_pc", out_pc, 32'h304);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the LemonPC core, sitting between fetch and execute. Consumes a fetched instruction via valid/ready handshake, drives the register-file read addresses, and captures decoded fields, immediate and operand values into a single-entry output register. A per-register busy scoreboard stalls RAW and WAW hazards until writeback retires the pending write.

## Interface

Parameters:
- XLEN, 32, data/PC width
- NREG, 32, architectural registers; address width AW = $clog2(NREG)

Ports:
- clk  in  1  clock; one clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch holds a valid instruction
- in_ready  out  1  decode accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- rf_rs1, rf_rs2  out  AW  register-file read addresses (combinational from in_inst)
- rf_data1, rf_data2  in  XLEN  register-file read data (combinational)
- wb_wen  in  1  writeback writes a register this cycle
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  execute redirect; kill held entry
- out_valid  out  1  output entry valid
- out_ready  in  1  execute accepts
- out_pc, out_src1, out_src2, out_imm  out  XLEN  registered PC, operands, immediate
- out_rd  out  AW  destination; out_rd_wen  out  1  writes rd
- out_op  out  4  op class (op_t)
- out_funct3  out  3; out_funct7b5  out  1

## Operation

- Decode classes by opcode: ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, ILLEGAL (any other opcode; rd_wen=0).
- Immediate: I/S/B/U/J formats, sign-extended to XLEN; R/SYSTEM/ILLEGAL imm = 0.
- rd_wen = 1 for ALU_R, ALU_I, LOAD, JAL, JALR, LUI, AUIPC, and forced 0 when rd == 0.
- Hazard = in_valid and any of: used rs1 busy; used rs2 busy; rd_wen and rd busy (WAW); used source or rd equals held entry's out_rd while out_valid && out_rd_wen. Register 0 never hazards. Unused sources (LUI, AUIPC, JAL, rs2 of I-types) ignored.
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Accept (in_valid && in_ready): output register loads all decoded fields; out_src1/2 from rf_data1/2.
- Issue (out_valid && out_ready): busy[out_rd] set if out_rd_wen.
- Retire: wb_wen && wb_rd != 0 clears busy[wb_rd]. Same-cycle set and clear of same index: set wins.
- flush: out_valid cleared next cycle, no issue that cycle, scoreboard untouched (held entry never set a bit).

## Timing

- Reset: out_valid 0, all out_* data 0, busy all 0. in_ready/rf_rs* combinational.
- Latency: accept at edge N -> out_valid high after edge N; back-to-back throughput 1/cycle with no hazards.
- out_* stable while out_valid && !out_ready.
- Without bypass, a consumer of register x is accepted no earlier than the cycle after wb_wen for x.
- rst mid-operation discards held entry and scoreboard.

## Configuration

- DECODE_BYPASS_EN defined: a source whose only hazard is busy[x] with same-cycle wb_wen && wb_rd == x is not a hazard; operand captured from wb_data. Also bit clears normally.
- Undefined: that case stalls one cycle; operands only from rf_data.

## Structure

- Package lemon_pkg: op_t enum, opcode constants, imm-format enum, XLEN default.
- Sub-module decode_logic: purely combinational inst -> {op, rs1, rs2, rd, rd_wen, uses_rs1, uses_rs2, imm, funct3, funct7b5}; decode_stage holds handshake, output register and scoreboard.

## Test plan

- addi x1,x0,5 accepted after reset, out_ready=1 -> next cycle out_op=ALU_I, out_imm=5, out_rd=1, busy[1]=1 after issue.
- addi x1 then add x2,x1,x1 -> add stalls (in_ready=0) until wb_wen with wb_rd=1; with DECODE_BYPASS_EN out_src1=out_src2=wb_data in that cycle, without it accepted one cycle later.
- out_ready=0 for 3 cycles with in_valid=1 -> out_* unchanged, in_ready=0, no busy change.
- flush with held entry and out_ready=0 -> out_valid=0 next cycle, busy unchanged.
- Immediates: beq offset -4 -> out_imm=0xFFFFFFFC; jal +2048 -> 0x00000800; lui 0xABCDE -> 0xABCDE000.
- Opcode 0x7F -> out_op=ILLEGAL, out_rd_wen=0; addi x0 -> rd_wen=0, no busy bit, next reader of x0 not stalled.
